// File: rtl/hpc_rx_endpoint.sv
// Destination-side endpoint of a 4-phase req/ack pulse synchronizer: sync req, deliver one event, return ack.
// Optional sticky abort flag `err` is built only when HPC_RX_ERR_EN is defined.
module hpc_rx_endpoint #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             src_clkB,
  input  logic             rstB,
  input  logic             req_in,
  input  logic             dst_ready,
  output logic             syncout,
  output logic             ack_out,
  output logic             busy,
  output logic [CNT_W-1:0] evt_cnt
`ifdef HPC_RX_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELIVER = 2'd1,
    ACK     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   syncout_q, syncout_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
`ifdef HPC_RX_ERR_EN
  logic                   err_q, err_d;
`endif

  // req_in is asynchronous to src_clkB; only the first stage may sample it.
  always_ff @(posedge src_clkB or negedge rstB) begin
    if (!rstB) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef HPC_RX_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_s) state_d = DELIVER;
      end
      DELIVER: begin
        // An accepted transfer takes priority over a withdrawn request.
        if (dst_ready) begin
          state_d = ACK;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (!req_s) begin
          state_d = IDLE;
`ifdef HPC_RX_ERR_EN
          err_d   = 1'b1;
`endif
        end
      end
      ACK: begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they leave the flops in step with it.
    syncout_d = (state_d == DELIVER);
    ack_d     = (state_d == ACK);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge src_clkB or negedge rstB) begin
    if (!rstB) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      syncout_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef HPC_RX_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      syncout_q <= syncout_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
`ifdef HPC_RX_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign syncout = syncout_q;
  assign ack_out = ack_q;
  assign busy    = busy_q;
  assign evt_cnt = cnt_q;
`ifdef HPC_RX_ERR_EN
  assign err     = err_q;
`endif

endmodule
